carga_operandos: RTL and testbench

//   Operand-capture and result-latch sequencer placed directly upstream of the 4-bit magnitude comparator.

---
 rtl/carga_operandos_if.sv | 28 ++
 rtl/carga_operandos.sv | 139 +++++++++++++
 tb/tb_carga_operandos.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/carga_operandos_if.sv
// Bus between the operand-capture sequencer and its surroundings: switches, button,
// clear, comparator flags in; operands, latched result and FSM state out.
interface carga_operandos_if;
  logic [3:0] din;
  logic       load;
  logic       clear;
  logic       aeqb;
  logic       agtb;
  logic       altb;
  logic [3:0] a;
  logic [3:0] b;
  logic       res_eq;
  logic       res_gt;
  logic       res_lt;
  logic       res_valid;
  logic       err;
  logic [1:0] state;

  modport master (
    output din, load, clear, aeqb, agtb, altb,
    input  a, b, res_eq, res_gt, res_lt, res_valid, err, state
  );

  modport slave (
    input  din, load, clear, aeqb, agtb, altb,
    output a, b, res_eq, res_gt, res_lt, res_valid, err, state
  );
endinterface

// File: rtl/carga_operandos.sv
// Operand-capture and result-latch sequencer for a 4-bit magnitude comparator:
// synchronises/debounces a push-button, loads A then B, latches the comparator flags.
module carga_operandos #(
  parameter int DB_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  carga_operandos_if.slave  bus
);

  localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_A    = 2'b00,
    ST_B    = 2'b01,
    ST_EVAL = 2'b10,
    ST_DONE = 2'b11
  } st_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic onehot3(input logic x, input logic y, input logic z);
    return (x & ~y & ~z) | (~x & y & ~z) | (~x & ~y & z);
  endfunction

  logic             load_p0;
  logic             load_p1;
  logic [CNT_W-1:0] cnt;
  logic             db_level;
  logic             db_level_p2;
  logic             press;

  st_t        st;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic       res_eq_r;
  logic       res_gt_r;
  logic       res_lt_r;
  logic       res_valid_r;
  logic       err_r;

  // Stage p0/p1: two-flop synchroniser; p2: debounced level history for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_p0     <= 1'b0;
      load_p1     <= 1'b0;
      cnt         <= '0;
      db_level    <= 1'b0;
      db_level_p2 <= 1'b0;
      press       <= 1'b0;
    end else begin
      load_p0 <= bus.load;
      load_p1 <= load_p0;
      if (load_p1 == db_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        db_level <= ~db_level;
      end else begin
        cnt <= sat_inc(cnt);
      end
      db_level_p2 <= db_level;
      press       <= db_level & ~db_level_p2;
    end
  end

  // Sequencer: clear wins over press; the flags are sampled one cycle after B loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_A;
      a_r         <= '0;
      b_r         <= '0;
      res_eq_r    <= 1'b0;
      res_gt_r    <= 1'b0;
      res_lt_r    <= 1'b0;
      res_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (bus.clear) begin
      st          <= ST_A;
      a_r         <= '0;
      b_r         <= '0;
      res_eq_r    <= 1'b0;
      res_gt_r    <= 1'b0;
      res_lt_r    <= 1'b0;
      res_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (st)
        ST_A: begin
          if (press) begin
            a_r <= bus.din;
            st  <= ST_B;
          end
        end
        ST_B: begin
          if (press) begin
            b_r <= bus.din;
            st  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          res_eq_r    <= bus.aeqb;
          res_gt_r    <= bus.agtb;
          res_lt_r    <= bus.altb;
          err_r       <= ~onehot3(bus.aeqb, bus.agtb, bus.altb);
          res_valid_r <= 1'b1;
          st          <= ST_DONE;
        end
        ST_DONE: begin
          // A new round keeps the old B so the comparator sees a fresh pair only after B reloads
          if (press) begin
            a_r         <= bus.din;
            res_eq_r    <= 1'b0;
            res_gt_r    <= 1'b0;
            res_lt_r    <= 1'b0;
            res_valid_r <= 1'b0;
            err_r       <= 1'b0;
            st          <= ST_B;
          end
        end
        default: st <= ST_A;
      endcase
    end
  end

  assign bus.a         = a_r;
  assign bus.b         = b_r;
  assign bus.res_eq    = res_eq_r;
  assign bus.res_gt    = res_gt_r;
  assign bus.res_lt    = res_lt_r;
  assign bus.res_valid = res_valid_r;
  assign bus.err       = err_r;
  assign bus.state     = st;

endmodule

// File: tb/tb_carga_operandos.sv
// Bench for carga_operandos: behavioural comparator, button stimulus and a result scoreboard.
module tb_carga_operandos;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_bad = 1'b0;
  logic rv_prev = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] sb[$];

  carga_operandos_if bus_if();

  carga_operandos #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Behavioural comparator; force_bad injects an illegal flag pattern
  assign bus_if.aeqb = force_bad ? 1'b1 : (bus_if.a == bus_if.b);
  assign bus_if.agtb = force_bad ? 1'b1 : (bus_if.a > bus_if.b);
  assign bus_if.altb = force_bad ? 1'b0 : (bus_if.a < bus_if.b);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input logic [3:0] av, input logic [3:0] bv, input logic bad);
    if (bad) return 4'b1101;
    return {av == bv, av > bv, av < bv, 1'b0};
  endfunction

  // Scoreboard: compare latched result whenever res_valid rises
  always @(negedge clk) begin
    if (rst_n && bus_if.res_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", 32'd1, 32'd0);
      end else begin
        check_eq("sb_result", {bus_if.res_eq, bus_if.res_gt, bus_if.res_lt, bus_if.err}, sb.pop_front());
      end
    end
    rv_prev <= rst_n & bus_if.res_valid;
  end

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    bus_if.din  = v;
    bus_if.load = 1'b1;
    repeat (10) @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_a"}, bus_if.a, 0);
    check_eq({tag, "_b"}, bus_if.b, 0);
    check_eq({tag, "_res"}, {bus_if.res_eq, bus_if.res_gt, bus_if.res_lt}, 0);
    check_eq({tag, "_valid"}, bus_if.res_valid, 0);
    check_eq({tag, "_err"}, bus_if.err, 0);
    check_eq({tag, "_state"}, bus_if.state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.din   = 4'd0;
    bus_if.load  = 1'b0;
    bus_if.clear = 1'b0;

    // Test 1: reset and idle
    repeat (3) @(negedge clk);
    check_idle("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_rel");
    repeat (20) @(negedge clk);
    check_idle("idle20");

    // Test 2: edge-exact A load, then B and result
    @(negedge clk);
    bus_if.din  = 4'd9;
    bus_if.load = 1'b1;
    repeat (7) @(posedge clk);
    #1 check_eq("a_edge7", bus_if.a, 0);
    @(posedge clk);
    #1 check_eq("a_edge8", bus_if.a, 9);
    check_eq("st_after_a", bus_if.state, 1);
    repeat (4) @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
    sb.push_back(exp_flags(4'd9, 4'd3, 1'b0));
    bus_if.din  = 4'd3;
    bus_if.load = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_eq("b_edge8", bus_if.b, 3);
    check_eq("st_eval", bus_if.state, 2);
    check_eq("valid_in_eval", bus_if.res_valid, 0);
    @(posedge clk);
    #1 check_eq("st_done", bus_if.state, 3);
    check_eq("res_gt", bus_if.res_gt, 1);
    check_eq("valid_done", bus_if.res_valid, 1);
    check_eq("err_done", bus_if.err, 0);
    @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("hold_done", bus_if.state, 3);

    // Test 3: bouncy press yields a single press
    do_clear();
    check_idle("clr3");
    bus_if.din = 4'hC;
    for (int i = 0; i < 4; i++) begin
      bus_if.load = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    check_eq("bounce_no_press", bus_if.state, 0);
    bus_if.load = 1'b1;
    repeat (10) @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("bounce_a", bus_if.a, 4'hC);
    check_eq("bounce_st", bus_if.state, 1);
    check_eq("bounce_b", bus_if.b, 0);

    // Test 4: equal round, then a new round from ST_DONE
    do_clear();
    press(4'd5);
    sb.push_back(exp_flags(4'd5, 4'd5, 1'b0));
    press(4'd5);
    check_eq("eq_res", bus_if.res_eq, 1);
    check_eq("eq_valid", bus_if.res_valid, 1);
    press(4'd2);
    check_eq("nr_valid", bus_if.res_valid, 0);
    check_eq("nr_res", {bus_if.res_eq, bus_if.res_gt, bus_if.res_lt}, 0);
    check_eq("nr_a", bus_if.a, 2);
    check_eq("nr_b", bus_if.b, 5);
    check_eq("nr_st", bus_if.state, 1);
    sb.push_back(exp_flags(4'd2, 4'd7, 1'b0));
    press(4'd7);
    check_eq("lt_res", bus_if.res_lt, 1);
    check_eq("lt_valid", bus_if.res_valid, 1);

    // Test 5: illegal flag pattern raises err
    press(4'd6);
    force_bad = 1'b1;
    sb.push_back(exp_flags(4'd6, 4'd6, 1'b1));
    press(4'd6);
    force_bad = 1'b0;
    check_eq("err_set", bus_if.err, 1);
    check_eq("err_valid", bus_if.res_valid, 1);
    press(4'd1);
    check_eq("err_cleared", bus_if.err, 0);
    check_eq("err_nr_valid", bus_if.res_valid, 0);
    check_eq("err_nr_st", bus_if.state, 1);

    // Test 6a: clear coincident with the press in ST_B
    do_clear();
    press(4'd4);
    check_eq("pre_clr_st", bus_if.state, 1);
    @(negedge clk);
    bus_if.din  = 4'hA;
    bus_if.load = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus_if.clear = 1'b1;
    @(posedge clk);
    #1 check_idle("clr_press");
    @(negedge clk);
    bus_if.clear = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
    check_idle("clr_discard");

    // Test 6b: asynchronous reset in ST_EVAL, button still held afterwards
    press(4'd3);
    @(negedge clk);
    bus_if.din  = 4'd5;
    bus_if.load = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_eq("pre_rst_eval", bus_if.state, 2);
    rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.din = 4'd8;
    repeat (12) @(negedge clk);
    bus_if.load = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("held_rst_a", bus_if.a, 8);
    check_eq("held_rst_st", bus_if.state, 1);
    check_eq("held_rst_b", bus_if.b, 0);

    check_eq("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
